// File: rtl/kernel_pingpong_buffer.sv
// Double-buffered kernel store for a convolutional unit.
// A loader fills one region (ping/pong) word by word, bank-major within each row,
// while compute reads whole rows (all banks at once) from the other, completed region.
// The two regions swap ownership through the per-region full flags.

module kernel_pingpong_buffer #(
  parameter int depth = 2,
  parameter int D     = 1 << depth,
  parameter int A     = 7,
  parameter int W     = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ld_start,
  input  logic [A:0]     ld_rows,
  input  logic           ld_valid,
  input  logic [W-1:0]   ld_data,
  output logic           ld_ready,
  output logic           ld_done,
  input  logic           rd_en,
  input  logic [A-1:0]   rd_addr,
  input  logic           rd_release,
  output logic           rd_ready,
  output logic [W*D-1:0] op,
  output logic           op_valid,
  output logic [1:0]     full
);

  localparam int ROWS = 1 << A;
  // Bank counter keeps at least one bit so a single-bank build still elaborates.
  localparam int BW = (D > 1) ? $clog2(D) : 1;
  localparam logic [A:0]    MAX_ROWS  = (A+1)'(ROWS);
  localparam logic [BW-1:0] LAST_BANK = BW'(D - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t        state;
  logic          wr_region;
  logic          rd_region;
  logic [BW-1:0] bank;
  logic [A-1:0]  row;
  logic [A:0]    rows_lat;
  logic [1:0]    full_next;

  logic          xfer;
  logic          last_word;
  logic          start_ok;
  logic          release_ok;
  logic          read_ok;

  // Kernel storage: region x bank x row. Never cleared, so stale rows stay readable.
  logic [W-1:0] mem [2][D][ROWS];

  // Handshake and control decodes shared by the loader, the flags and the read port.
  always_comb begin
    xfer       = (state == LOAD) && ld_valid;
    last_word  = (bank == LAST_BANK) && ({1'b0, row} == (rows_lat - (A+1)'(1)));
    start_ok   = (state == IDLE) && ld_start && (ld_rows != '0) &&
                 (ld_rows <= MAX_ROWS) && !full[wr_region];
    release_ok = rd_release && full[rd_region];
    read_ok    = rd_en && full[rd_region];
  end

  assign ld_ready = (state == LOAD);
  assign rd_ready = full[rd_region];

  // Load FSM: latch the row count on start, walk bank then row, hand off the region on the last word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_region <= 1'b0;
      bank      <= '0;
      row       <= '0;
      rows_lat  <= '0;
      ld_done   <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= LOAD;
            rows_lat <= ld_rows;
            bank     <= '0;
            row      <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (last_word) begin
              ld_done   <= 1'b1;
              wr_region <= ~wr_region;
              state     <= IDLE;
            end else if (bank == LAST_BANK) begin
              bank <= '0;
              row  <= row + A'(1);
            end else begin
              bank <= bank + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next full flags: a release clears only an already-full region, so it never collides with a completing load.
  always_comb begin
    full_next = full;
    if (release_ok) begin
      full_next[rd_region] = 1'b0;
    end
    if (xfer && last_word) begin
      full_next[wr_region] = 1'b1;
    end
  end

  // Region ownership flags and the read-side region pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full      <= 2'b00;
      rd_region <= 1'b0;
    end else begin
      full <= full_next;
      if (release_ok) begin
        rd_region <= ~rd_region;
      end
    end
  end

  // Kernel word write; suppressed during reset so an abandoned load leaves nothing behind that cycle.
  always_ff @(posedge CLK) begin
    if (!RST && xfer) begin
      mem[wr_region][bank][row] <= ld_data;
    end
  end

  // Row read: all banks of the current read region, registered; a same-cycle release still reads the old region.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op       <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= read_ok;
      if (read_ok) begin
        for (int b = 0; b < D; b++) begin
          op[W*b +: W] <= mem[rd_region][b][rd_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_pingpong_buffer.sv
// Self-checking bench for kernel_pingpong_buffer: directed scenarios plus a
// randomized phase, all checked against a word/region-level reference model.

module tb_kernel_pingpong_buffer;

  localparam int DEPTH = 2;
  localparam int D     = 1 << DEPTH;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int ROWS  = 1 << A;

  logic           CLK = 1'b0;
  logic           t_rst = 1'b0;
  logic           t_start = 1'b0;
  logic [A:0]     t_rows = '0;
  logic           t_valid = 1'b0;
  logic [W-1:0]   t_data = '0;
  logic           t_en = 1'b0;
  logic [A-1:0]   t_addr = '0;
  logic           t_rel = 1'b0;

  logic           ld_ready;
  logic           ld_done;
  logic           rd_ready;
  logic [W*D-1:0] op;
  logic           op_valid;
  logic [1:0]     full;

  // Reference model state
  logic [W-1:0]   m_mem   [2][D][ROWS];
  bit             m_known [2][D][ROWS];
  bit             m_loading;
  int             m_k;
  int             m_rows;
  logic           m_wr;
  logic           m_rd;
  logic [1:0]     m_full;
  bit             m_done;
  bit             m_opv;
  logic [W*D-1:0] m_op;
  bit             m_op_known;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  kernel_pingpong_buffer #(
    .depth(DEPTH),
    .D(D),
    .A(A),
    .W(W)
  ) dut (
    .CLK(CLK),
    .RST(t_rst),
    .ld_start(t_start),
    .ld_rows(t_rows),
    .ld_valid(t_valid),
    .ld_data(t_data),
    .ld_ready(ld_ready),
    .ld_done(ld_done),
    .rd_en(t_en),
    .rd_addr(t_addr),
    .rd_release(t_rel),
    .rd_ready(rd_ready),
    .op(op),
    .op_valid(op_valid),
    .full(full)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [W*D-1:0] got, input logic [W*D-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    logic [1:0] f;
    logic w, r;
    f = m_full;
    w = m_wr;
    r = m_rd;
    if (t_rst) begin
      m_loading  = 0;
      m_full     = 2'b00;
      m_wr       = 1'b0;
      m_rd       = 1'b0;
      m_done     = 0;
      m_opv      = 0;
      m_op       = '0;
      m_op_known = 1;
      return;
    end
    m_done = 0;
    m_opv  = 0;
    if (t_en && f[r]) begin
      m_opv      = 1;
      m_op_known = 1;
      for (int b = 0; b < D; b++) begin
        if (!m_known[r][b][t_addr]) m_op_known = 0;
        m_op[W*b +: W] = m_mem[r][b][t_addr];
      end
    end
    if (m_loading) begin
      if (t_valid) begin
        m_mem[w][m_k % D][m_k / D]   = t_data;
        m_known[w][m_k % D][m_k / D] = 1;
        m_k++;
        if (m_k == m_rows * D) begin
          m_done    = 1;
          m_full[w] = 1'b1;
          m_wr      = ~w;
          m_loading = 0;
        end
      end
    end else if (t_start && int'(t_rows) >= 1 && int'(t_rows) <= ROWS && !f[w]) begin
      m_loading = 1;
      m_k       = 0;
      m_rows    = int'(t_rows);
    end
    if (t_rel && f[r]) begin
      m_full[r] = 1'b0;
      m_rd      = ~r;
    end
  endtask

  // One clock: update the model, let the DUT take the edge, compare every output.
  task automatic applyStimulus();
    model_update();
    @(posedge CLK);
    #1;
    if (ld_done) done_seen++;
    checkOutput("ld_ready", ld_ready, m_loading);
    checkOutput("ld_done", ld_done, m_done);
    checkOutput("full", full, m_full);
    checkOutput("rd_ready", rd_ready, m_full[m_rd]);
    checkOutput("op_valid", op_valid, m_opv);
    if (m_op_known) checkOutput("op", op, m_op);
  endtask

  task automatic load_kernel(input int rows, input int base, input bit gaps);
    int k;
    t_start = 1'b1;
    t_rows  = (A+1)'(rows);
    applyStimulus();
    t_start = 1'b0;
    k = 0;
    while (k < rows * D) begin
      t_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      t_data  = W'(base + k);
      if (t_valid) k++;
      applyStimulus();
    end
    t_valid = 1'b0;
  endtask

  task automatic read_row(input int addr, input bit rel);
    t_en   = 1'b1;
    t_addr = A'(addr);
    t_rel  = rel;
    applyStimulus();
    t_en  = 1'b0;
    t_rel = 1'b0;
  endtask

  initial begin
    int d0;
    int sel;
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < D; b++)
        for (int i = 0; i < ROWS; i++)
          m_known[r][b][i] = 0;
    m_op_known = 0;

    // Reset state
    t_rst = 1'b1;
    applyStimulus();
    applyStimulus();
    t_rst = 1'b0;
    checkOutput("rst_full", full, 2'b00);
    checkOutput("rst_op", op, '0);

    // Basic load of 4 rows, values 0..15
    d0 = done_seen;
    load_kernel(4, 0, 0);
    applyStimulus();
    checkOutput("t1_done_count", done_seen - d0, 1);
    checkOutput("t1_full", full, 2'b01);
    read_row(2, 0);
    checkOutput("t1_op_valid", op_valid, 1'b1);
    checkOutput("t1_op", op, {16'd11, 16'd10, 16'd9, 16'd8});

    // Pong load 100..115, both full, start blocked, release to region 1
    load_kernel(4, 100, 1);
    checkOutput("t2_full", full, 2'b11);
    t_start = 1'b1;
    t_rows  = 8'd4;
    applyStimulus();
    t_start = 1'b0;
    applyStimulus();
    checkOutput("t2_blocked_ready", ld_ready, 1'b0);
    t_rel = 1'b1;
    applyStimulus();
    t_rel = 1'b0;
    checkOutput("t2_rel_full", full, 2'b10);
    checkOutput("t2_rd_ready", rd_ready, 1'b1);
    read_row(0, 0);
    checkOutput("t2_op", op, {16'd103, 16'd102, 16'd101, 16'd100});

    // Reads and release with nothing full
    t_rel = 1'b1;
    applyStimulus();
    t_rel = 1'b0;
    checkOutput("t3_full", full, 2'b00);
    read_row(1, 0);
    checkOutput("t3_op_valid", op_valid, 1'b0);
    checkOutput("t3_op_hold", op, {16'd103, 16'd102, 16'd101, 16'd100});
    t_rel = 1'b1;
    applyStimulus();
    t_rel = 1'b0;
    load_kernel(1, 500, 0);
    checkOutput("t3_ptr_full", full, 2'b01);
    checkOutput("t3_ptr_rd_ready", rd_ready, 1'b1);

    // Reset in the middle of a load
    t_start = 1'b1;
    t_rows  = 8'd4;
    applyStimulus();
    t_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      t_valid = 1'b1;
      t_data  = W'(i);
      applyStimulus();
    end
    t_valid = 1'b0;
    t_rst = 1'b1;
    applyStimulus();
    t_rst = 1'b0;
    checkOutput("t4_ready", ld_ready, 1'b0);
    checkOutput("t4_full", full, 2'b00);
    load_kernel(4, 200, 1);
    checkOutput("t4_reload_full", full, 2'b01);
    read_row(3, 0);
    checkOutput("t4_op", op, {16'd215, 16'd214, 16'd213, 16'd212});

    // Simultaneous read and release with both full
    load_kernel(4, 300, 0);
    checkOutput("t5_full11", full, 2'b11);
    read_row(1, 1);
    checkOutput("t5_op", op, {16'd207, 16'd206, 16'd205, 16'd204});
    checkOutput("t5_full", full, 2'b10);
    checkOutput("t5_rd_ready", rd_ready, 1'b1);

    // Illegal row counts ignored
    t_start = 1'b1;
    t_rows  = 8'd0;
    applyStimulus();
    checkOutput("t6_rows0", ld_ready, 1'b0);
    t_rows = 8'd129;
    applyStimulus();
    checkOutput("t6_rows129", ld_ready, 1'b0);
    t_start = 1'b0;
    applyStimulus();
    checkOutput("t6_idle", ld_ready, 1'b0);

    // Short reload keeps older rows above the new row count
    t_rel = 1'b1;
    applyStimulus();
    t_rel = 1'b0;
    load_kernel(2, 400, 1);
    checkOutput("t7_full", full, 2'b01);
    read_row(3, 0);
    checkOutput("t7_stale_op", op, {16'd215, 16'd214, 16'd213, 16'd212});
    read_row(1, 0);
    checkOutput("t7_new_op", op, {16'd407, 16'd406, 16'd405, 16'd404});

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      t_rst   = ($urandom_range(0, 299) == 0);
      t_start = ($urandom_range(0, 7) == 0);
      sel     = $urandom_range(0, 9);
      if (sel == 0)      t_rows = 8'd0;
      else if (sel == 1) t_rows = 8'd129;
      else               t_rows = (A+1)'($urandom_range(1, 4));
      t_valid = ($urandom_range(0, 3) != 0);
      t_data  = W'($urandom);
      t_en    = ($urandom_range(0, 1) == 1);
      t_addr  = A'($urandom_range(0, 5));
      t_rel   = ($urandom_range(0, 15) == 0);
      applyStimulus();
    end
    t_rst   = 1'b0;
    t_start = 1'b0;
    t_valid = 1'b0;
    t_en    = 1'b0;
    t_rel   = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
